// File: rtl/thread_sel_pkg.sv
// Shared definitions for the thread mask serializer.
//   state_t   : serializer control states (IDLE waits for a mask, ISSUE hands out IDs)
//   MODE_LSB  : fixed priority, lowest thread ID first
//   MODE_RR   : round-robin, search resumes just after the last issued ID
package thread_sel_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   localparam int MODE_LSB = 0;
   localparam int MODE_RR  = 1;

endpackage

// File: rtl/rotating_priority_encoder.sv
// Combinational rotating priority encoder.
// Finds the first set bit of 'mask' at or above 'start', wrapping from
// WIDTH-1 back to 0.
//   mask   in  WIDTH      request bits
//   start  in  IDX_WIDTH  position where the search begins
//   index  out IDX_WIDTH  first set bit found (0 when none)
//   found  out 1          at least one bit of mask is set
module rotating_priority_encoder #(
   parameter int WIDTH     = 32,
   parameter int IDX_WIDTH = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]     mask,
   input  logic [IDX_WIDTH-1:0] start,
   output logic [IDX_WIDTH-1:0] index,
   output logic                 found
);

   logic [2*WIDTH-1:0] doubled;
   logic [2*WIDTH-1:0] masked;
   int                 pos;
   int                 wrapped;

   // The mask is duplicated so that a single upward scan covers the wrap.
   // Bits of the lower copy below 'start' are removed by a thermometer, so
   // the lowest surviving bit is the first request at or after 'start'.
   always_comb begin
      doubled = {mask, mask};
      masked  = '0;
      found   = 1'b0;
      pos     = 0;
      for (int i = 0; i < 2*WIDTH; i++) begin
         masked[i] = doubled[i] & (i >= int'(start));
      end
      for (int i = 2*WIDTH-1; i >= 0; i--) begin
         if (masked[i]) begin
            found = 1'b1;
            pos   = i;
         end
      end
      wrapped = (pos >= WIDTH) ? (pos - WIDTH) : pos;
      index   = IDX_WIDTH'(wrapped);
   end

endmodule

// File: rtl/thread_mask_serializer.sv
// Thread mask serializer: accepts an active-thread mask and issues the ID of
// every set bit, one per cycle, over a valid/ready interface.
//   clk        in   clock, all state on rising edge
//   rst_n      in   synchronous reset, active low
//   flush      in   synchronous abort of the pending mask (no done pulse)
//   in_valid   in   mask offered
//   in_mask    in   thread mask, bit i = thread i
//   in_ready   out  block can accept a mask (IDLE)
//   out_valid  out  out_id valid (ISSUE)
//   out_ready  in   sink accepts out_id
//   out_id     out  thread ID being issued
//   out_last   out  out_id is the final set bit of the mask
//   out_count  out  IDs still pending, including out_id
//   done       out  one-cycle pulse once a mask is fully issued
module thread_mask_serializer
   import thread_sel_pkg::*;
#(
   parameter int INPUT_WIDTH  = 32,
   parameter int OUTPUT_WIDTH = $clog2(INPUT_WIDTH),
   parameter int COUNT_WIDTH  = $clog2(INPUT_WIDTH + 1),
   parameter int RR_MODE      = MODE_LSB
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   input  logic [INPUT_WIDTH-1:0]  in_mask,
   output logic                    in_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUTPUT_WIDTH-1:0] out_id,
   output logic                    out_last,
   output logic [COUNT_WIDTH-1:0]  out_count,
   output logic                    done
);

   state_t                  state, state_next;
   logic [INPUT_WIDTH-1:0]  pending, pending_next;
   logic [OUTPUT_WIDTH-1:0] ptr, ptr_next;
   logic                    done_next;
   logic [OUTPUT_WIDTH-1:0] first_idx;
   logic                    first_found;

   rotating_priority_encoder #(
      .WIDTH     (INPUT_WIDTH),
      .IDX_WIDTH (OUTPUT_WIDTH)
   ) u_encoder (
      .mask  (pending),
      .start (ptr),
      .index (first_idx),
      .found (first_found)
   );

   // Every output is a function of registered state only, so nothing on the
   // input side can ripple combinationally through to the sink.
   always_comb begin
      out_count = '0;
      for (int i = 0; i < INPUT_WIDTH; i++) begin
         out_count = out_count + COUNT_WIDTH'(pending[i]);
      end
      in_ready  = (state == IDLE);
      out_valid = (state == ISSUE);
      out_id    = first_found ? first_idx : '0;
      out_last  = (out_count == COUNT_WIDTH'(1));
   end

   // Next-state logic. Flush wins over any handshake and blocks capture of a
   // mask offered in the same cycle. A zero mask is consumed in IDLE and only
   // produces the done pulse.
   always_comb begin
      state_next   = state;
      pending_next = pending;
      ptr_next     = ptr;
      done_next    = 1'b0;
      if (flush) begin
         state_next   = IDLE;
         pending_next = '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  pending_next = in_mask;
                  if (|in_mask) begin
                     state_next = ISSUE;
                  end else begin
                     done_next = 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (out_ready) begin
                  pending_next[out_id] = 1'b0;
                  if (RR_MODE == MODE_RR) begin
                     ptr_next = (out_id == OUTPUT_WIDTH'(INPUT_WIDTH - 1)) ?
                                '0 : out_id + 1'b1;
                  end
                  if (out_last) begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // State register; the round-robin pointer survives flushes and is only
   // cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         pending <= '0;
         ptr     <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         pending <= pending_next;
         ptr     <= ptr_next;
         done    <= done_next;
      end
   end

endmodule

// File: tb/tb_thread_mask_serializer.sv
// Directed testbench for thread_mask_serializer with INPUT_WIDTH=8.
// Two instances share all inputs: one in LSB mode, one in round-robin mode.
module tb_thread_mask_serializer;
   import thread_sel_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_mask;
   logic       out_ready;

   logic       in_ready_l, out_valid_l, out_last_l, done_l;
   logic [2:0] out_id_l;
   logic [3:0] out_count_l;
   logic       in_ready_r, out_valid_r, out_last_r, done_r;
   logic [2:0] out_id_r;
   logic [3:0] out_count_r;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   thread_mask_serializer #(.INPUT_WIDTH(8), .RR_MODE(MODE_LSB)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_mask(in_mask), .in_ready(in_ready_l), .out_valid(out_valid_l),
      .out_ready(out_ready), .out_id(out_id_l), .out_last(out_last_l),
      .out_count(out_count_l), .done(done_l)
   );

   thread_mask_serializer #(.INPUT_WIDTH(8), .RR_MODE(MODE_RR)) dut_rr (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_mask(in_mask), .in_ready(in_ready_r), .out_valid(out_valid_r),
      .out_ready(out_ready), .out_id(out_id_r), .out_last(out_last_r),
      .out_count(out_count_r), .done(done_r)
   );

   // Advance one clock; outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mask = '0; out_ready = 1'b1;
      step(); step();
      checks++;
      if ({in_ready_l, out_valid_l, out_id_l, out_last_l, out_count_l, done_l} !== 11'b1_0_000_0_0000_0) begin
         errors++;
         $display("[TB] FAIL reset_lsb got in_ready=%b out_valid=%b id=%0d last=%b count=%0d done=%b exp 1 0 0 0 0 0",
                  in_ready_l, out_valid_l, out_id_l, out_last_l, out_count_l, done_l);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_lsb_issue();
      logic [2:0] ids [4] = '{3'd1, 3'd2, 3'd5, 3'd7};
      in_valid = 1'b1; in_mask = 8'b1010_0110; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid_l !== 1'b1 || out_id_l !== ids[i] || out_count_l !== 4'(4 - i) ||
             out_last_l !== (i == 3) || done_l !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lsb_issue beat %0d got valid=%b id=%0d count=%0d last=%b done=%b exp 1 %0d %0d %b 0",
                     i, out_valid_l, out_id_l, out_count_l, out_last_l, done_l, ids[i], 4 - i, i == 3);
         end
         step();
      end
      checks++;
      if (done_l !== 1'b1 || out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin
         errors++;
         $display("[TB] FAIL lsb_done got done=%b valid=%b in_ready=%b exp 1 0 1", done_l, out_valid_l, in_ready_l);
      end
      step();
      checks++;
      if (done_l !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lsb_done_pulse got done=%b exp 0", done_l);
      end
   endtask

   task automatic test_backpressure();
      in_valid = 1'b1; in_mask = 8'b0001_0010; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid_l !== 1'b1 || out_id_l !== 3'd1 || out_count_l !== 4'd2 || out_last_l !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold cycle %0d got valid=%b id=%0d count=%0d last=%b exp 1 1 2 0",
                     i, out_valid_l, out_id_l, out_count_l, out_last_l);
         end
         step();
      end
      out_ready = 1'b1;
      checks++;
      if (out_id_l !== 3'd1 || out_count_l !== 4'd2) begin
         errors++;
         $display("[TB] FAIL bp_first got id=%0d count=%0d exp 1 2", out_id_l, out_count_l);
      end
      step();
      checks++;
      if (out_valid_l !== 1'b1 || out_id_l !== 3'd4 || out_count_l !== 4'd1 || out_last_l !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_second got valid=%b id=%0d count=%0d last=%b exp 1 4 1 1",
                  out_valid_l, out_id_l, out_count_l, out_last_l);
      end
      step();
      checks++;
      if (done_l !== 1'b1 || out_valid_l !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_done got done=%b valid=%b exp 1 0", done_l, out_valid_l);
      end
      step();
   endtask

   task automatic test_zero_mask();
      in_valid = 1'b1; in_mask = 8'h00;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid_l !== 1'b0 || done_l !== 1'b1 || in_ready_l !== 1'b1 || out_count_l !== 4'd0) begin
         errors++;
         $display("[TB] FAIL zero_mask got valid=%b done=%b in_ready=%b count=%0d exp 0 1 1 0",
                  out_valid_l, done_l, in_ready_l, out_count_l);
      end
      step();
      checks++;
      if (out_valid_l !== 1'b0 || done_l !== 1'b0 || in_ready_l !== 1'b1) begin
         errors++;
         $display("[TB] FAIL zero_mask_after got valid=%b done=%b in_ready=%b exp 0 0 1",
                  out_valid_l, done_l, in_ready_l);
      end
   endtask

   task automatic test_single_bit();
      in_valid = 1'b1; in_mask = 8'b1000_0000; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid_l !== 1'b1 || out_id_l !== 3'd7 || out_last_l !== 1'b1 || out_count_l !== 4'd1) begin
         errors++;
         $display("[TB] FAIL single_bit got valid=%b id=%0d last=%b count=%0d exp 1 7 1 1",
                  out_valid_l, out_id_l, out_last_l, out_count_l);
      end
      step();
      checks++;
      if (done_l !== 1'b1 || in_ready_l !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_bit_done got done=%b in_ready=%b exp 1 1", done_l, in_ready_l);
      end
      step();
   endtask

   task automatic test_flush();
      in_valid = 1'b1; in_mask = 8'hFF; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_id_l !== 3'd0 || out_count_l !== 4'd8) begin
         errors++;
         $display("[TB] FAIL flush_first got id=%0d count=%0d exp 0 8", out_id_l, out_count_l);
      end
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (out_valid_l !== 1'b0 || done_l !== 1'b0 || in_ready_l !== 1'b1 || out_count_l !== 4'd0) begin
         errors++;
         $display("[TB] FAIL flush_abort got valid=%b done=%b in_ready=%b count=%0d exp 0 0 1 0",
                  out_valid_l, done_l, in_ready_l, out_count_l);
      end
      flush = 1'b1; in_valid = 1'b1; in_mask = 8'h0F;
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid_l !== 1'b0 || out_count_l !== 4'd0 || done_l !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_blocks_capture got valid=%b count=%0d done=%b exp 0 0 0",
                  out_valid_l, out_count_l, done_l);
      end
      step();
   endtask

   task automatic test_round_robin();
      logic [2:0] rr_ids  [3] = '{3'd7, 3'd0, 3'd1};
      logic [2:0] lsb_ids [3] = '{3'd0, 3'd1, 3'd7};
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; in_valid = 1'b1; in_mask = 8'b0000_0110; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_id_r !== 3'd1 || out_count_r !== 4'd2) begin
         errors++;
         $display("[TB] FAIL rr_a0 got id=%0d count=%0d exp 1 2", out_id_r, out_count_r);
      end
      step();
      checks++;
      if (out_id_r !== 3'd2 || out_last_r !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rr_a1 got id=%0d last=%b exp 2 1", out_id_r, out_last_r);
      end
      step();
      in_valid = 1'b1; in_mask = 8'b1000_0011;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid_r !== 1'b1 || out_id_r !== rr_ids[i] || out_count_r !== 4'(3 - i) ||
             out_id_l !== lsb_ids[i]) begin
            errors++;
            $display("[TB] FAIL rr_b beat %0d got rr_id=%0d rr_count=%0d lsb_id=%0d exp %0d %0d %0d",
                     i, out_id_r, out_count_r, out_id_l, rr_ids[i], 3 - i, lsb_ids[i]);
         end
         step();
      end
      checks++;
      if (done_r !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rr_done got done=%b exp 1", done_r);
      end
      step();
   endtask

   task automatic test_reset_mid_issue();
      // ptr is 2 here; after one beat of 8'hFF it is 3.
      in_valid = 1'b1; in_mask = 8'hFF; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      checks++;
      if (out_id_r !== 3'd3) begin
         errors++;
         $display("[TB] FAIL rr_resume got id=%0d exp 3", out_id_r);
      end
      rst_n = 1'b0;
      step();
      checks++;
      if ({in_ready_r, out_valid_r, out_id_r, out_last_r, out_count_r, done_r} !== 11'b1_0_000_0_0000_0) begin
         errors++;
         $display("[TB] FAIL reset_mid got in_ready=%b out_valid=%b id=%0d last=%b count=%0d done=%b exp 1 0 0 0 0 0",
                  in_ready_r, out_valid_r, out_id_r, out_last_r, out_count_r, done_r);
      end
      rst_n = 1'b1; in_valid = 1'b1; in_mask = 8'b1000_0001;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_id_r !== 3'd0 || out_count_r !== 4'd2) begin
         errors++;
         $display("[TB] FAIL reset_ptr got id=%0d count=%0d exp 0 2", out_id_r, out_count_r);
      end
      step(); step(); step();
   endtask

   initial begin
      test_reset();
      test_lsb_issue();
      test_backpressure();
      test_zero_mask();
      test_single_bit();
      test_flush();
      test_round_robin();
      test_reset_mid_issue();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
